sem_mailbox: RTL and testbench

Single-clock semaphore mailbox between two `cpu` instances. It takes words from the producer CPU's semaphore output side (`sem_data_out`, `sem_data_valid_out`, `sem_data_empty`). It presents them in order to the consumer CPU's semaphore input side (`sem_data_in`, `sem_data_valid_in`, `sem_data_read`). Internally it is a show-ahead circular FIFO with occupancy tracking and sticky overflow/underflow flags.

---
 rtl/sem_mailbox_pkg.sv | 10 +
 rtl/sem_mem.sv | 31 +++
 rtl/sem_mailbox.sv | 87 ++++++++
 tb/tb_sem_mailbox.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sem_mailbox_pkg.sv
// Shared constants for the semaphore mailbox between the two cpu instances.
package sem_mailbox_pkg;

  // Word width of the cpu semaphore path.
  localparam int unsigned DATA_WIDTH = 1;

  // Default mailbox depth: a power of two, at least 2.
  localparam int unsigned SEM_DEPTH = 4;

endpackage : sem_mailbox_pkg

// File: rtl/sem_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, cleared on reset.
module sem_mem #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage update; reset wipes every entry so no stale word can surface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : sem_mem

// File: rtl/sem_mailbox.sv
// Show-ahead circular FIFO carrying semaphore words from a producer cpu to a consumer cpu.
module sem_mailbox
  import sem_mailbox_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = sem_mailbox_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = SEM_DEPTH,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_space,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_read,
  output logic [PTR_WIDTH:0]   count,
  output logic                 err_ovf,
  output logic                 err_unf,
  input  logic                 err_clr
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 is_full;
  logic                 is_empty;
  logic                 push;
  logic                 pop;

  assign is_full  = (count == CNT_W'(DEPTH));
  assign is_empty = (count == '0);

  // A full mailbox still accepts a word when the head leaves in the same cycle.
  assign pop  = rd_read && !is_empty;
  assign push = wr_valid && (!is_full || pop);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (err_clr) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (wr_valid && !push)   err_ovf <= 1'b1;
      if (rd_read && is_empty) err_unf <= 1'b1;
    end
  end

  sem_mem #(
    .WIDTH  (DATA_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign rd_valid = !is_empty;
  assign wr_space = !is_full;

endmodule : sem_mailbox

// File: tb/tb_sem_mailbox.sv
// Self-checking bench for sem_mailbox: directed scenarios then random traffic vs a queue model.
module tb_sem_mailbox;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] wr_data;
  logic       wr_valid;
  logic       wr_space;
  logic [0:0] rd_data;
  logic       rd_valid;
  logic       rd_read;
  logic [2:0] count;
  logic       err_ovf;
  logic       err_unf;
  logic       err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit q[$];
  bit m_ovf;
  bit m_unf;

  sem_mailbox #(
    .DATA_WIDTH (1),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_space (wr_space),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_read  (rd_read),
    .count    (count),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},    32'(count),    32'(q.size()));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    check({tag, ".wr_space"}, 32'(wr_space), 32'(q.size() != DEPTH));
    check({tag, ".err_ovf"},  32'(err_ovf),  32'(m_ovf));
    check({tag, ".err_unf"},  32'(err_unf),  32'(m_unf));
    if (q.size() != 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
  endtask

  // One clock of traffic: drive, clock, advance model, compare.
  task automatic step(input string tag, input bit wv, input bit wd, input bit rr, input bit ec);
    bit do_pop;
    bit do_push;
    wr_valid = wv;
    wr_data  = wd;
    rd_read  = rr;
    err_clr  = ec;
    @(posedge clk);
    do_pop  = rr && (q.size() != 0);
    do_push = wv && ((q.size() < DEPTH) || do_pop);
    if (ec) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wv && !do_push)       m_ovf = 1'b1;
      if (rr && q.size() == 0)  m_unf = 1'b1;
    end
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(wd);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_read  = 1'b0;
    err_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    idle("idle");

    // Single word latency and pop
    step("push1", 1'b1, 1'b1, 1'b0, 1'b0);
    idle("hold");
    step("pop1", 1'b0, 1'b0, 1'b1, 1'b0);

    // Fill, overflow, drain in order
    step("fill0", 1'b1, 1'b1, 1'b0, 1'b0);
    step("fill1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("fill2", 1'b1, 1'b1, 1'b0, 1'b0);
    step("fill3", 1'b1, 1'b1, 1'b0, 1'b0);
    step("ovf",   1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b0, 1'b1, 1'b0);
    step("clr0", 1'b0, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step("refill", 1'b1, 1'(i), 1'b0, 1'b0);
    step("full_pp", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 1'b0, 1'b1, 1'b0);

    // Empty read with same-cycle push, then clear
    step("unf_push", 1'b1, 1'b1, 1'b1, 1'b0);
    step("clr1", 1'b0, 1'b0, 1'b0, 1'b1);
    step("pop_u", 1'b0, 1'b0, 1'b1, 1'b0);

    // Alternating stream through the pointer wrap
    step("alt0", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step("alt", 1'b1, 1'(i % 2 == 0), 1'b1, 1'b0);
    step("alt_end", 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    step("pre_ovf", 1'b1, 1'b1, 1'b1, 1'b0);
    wr_valid = 1'b0;
    rd_read  = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle("post_rst");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 99) < 60),
           1'($urandom),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sem_mailbox
